// File: rtl/softmax_argmax_decoder.sv
// Serial argmax over a packed vector of N IEEE-754 singles, one element per cycle.
// Reports winning index, raw probability, low-confidence and all-NaN flags with valid/ready.
module softmax_argmax_decoder #(
    parameter int          N      = 4,
    parameter int          IDXW   = $clog2(N),
    parameter logic [31:0] THRESH = 32'h3F000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*32-1:0] in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic [31:0]     out_prob,
    output logic            out_low_conf,
    output logic            out_all_nan
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // out_valid holds with stable outputs until that edge, and in_ready is high only in IDLE.

    // Monotone unsigned key for float ordering; -0 folds onto +0.
    function automatic logic [31:0] order_key(input logic [31:0] x);
        logic [31:0] v;
        v = (x == 32'h80000000) ? 32'h0 : x;
        return v[31] ? ~v : (v | 32'h80000000);
    endfunction

    localparam logic [31:0]     THRESH_KEY = order_key(THRESH);
    localparam logic [IDXW-1:0] LAST       = IDXW'(N - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state;

    logic [N*32-1:0] vec_q;
    logic [IDXW-1:0] cnt;
    logic            best_valid;
    logic [31:0]     best_key;
    logic [IDXW-1:0] best_idx;
    logic [31:0]     best_prob;

    logic [31:0]     elem;
    logic [31:0]     elem_key;
    logic            elem_nan;
    logic            take;
    logic            cand_valid;
    logic [31:0]     cand_key;
    logic [IDXW-1:0] cand_idx;
    logic [31:0]     cand_prob;

    assign in_ready = rst_n && (state == IDLE);

    // Strictly-greater replacement keeps the lowest index on ties; NaN never enters.
    always_comb begin
        elem       = vec_q[N*32-1 -: 32];
        elem_key   = order_key(elem);
        elem_nan   = (elem[30:23] == 8'hFF) && (elem[22:0] != 23'd0);
        take       = !elem_nan && (!best_valid || (elem_key > best_key));
        cand_valid = best_valid | take;
        cand_key   = take ? elem_key : best_key;
        cand_idx   = take ? cnt : best_idx;
        cand_prob  = take ? elem : best_prob;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            vec_q        <= '0;
            cnt          <= '0;
            best_valid   <= 1'b0;
            best_key     <= '0;
            best_idx     <= '0;
            best_prob    <= '0;
            out_valid    <= 1'b0;
            out_idx      <= '0;
            out_prob     <= '0;
            out_low_conf <= 1'b0;
            out_all_nan  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        vec_q      <= in_vec;
                        cnt        <= '0;
                        best_valid <= 1'b0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    vec_q      <= vec_q << 32;
                    cnt        <= cnt + IDXW'(1);
                    best_valid <= cand_valid;
                    best_key   <= cand_key;
                    best_idx   <= cand_idx;
                    best_prob  <= cand_prob;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        if (cand_valid) begin
                            out_idx      <= cand_idx;
                            out_prob     <= cand_prob;
                            out_low_conf <= cand_key < THRESH_KEY;
                            out_all_nan  <= 1'b0;
                        end else begin
                            out_idx      <= '0;
                            out_prob     <= 32'h7FC00000;
                            out_low_conf <= 1'b1;
                            out_all_nan  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
